// File: rtl/avalon_mem_burst_responder_pkg.sv
// Shared types and constants for the Avalon-MM burst responder.
//   t_rsp_state : command FSM states (idle, write burst, read burst)
//   byte_count  : byte lanes for a given data width
package avalon_mem_burst_responder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrBurst,
    StRdBurst
  } t_rsp_state;

  localparam int unsigned DefaultDataWidth = 512;
  localparam int unsigned DefaultByteCount = DefaultDataWidth / 8;

  function automatic int unsigned byte_count(int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/avalon_mem_responder_ram.sv
// Simple dual-port backing RAM for the burst responder.
//   clk_i, rst_ni             : clock, async active-low reset (read register only)
//   we_i, waddr_i, wdata_i,
//   wbe_i                     : byte-enabled write port
//   re_i, raddr_i, rdata_o    : registered read port, write-first on address collision
// The array itself is not reset; rdata_o resets to 0 and holds while re_i is low.
module avalon_mem_responder_ram #(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned MEM_DEPTH_LOG2 = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      we_i,
  input  logic [MEM_DEPTH_LOG2-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   wbe_i,
  input  logic                      re_i,
  input  logic [MEM_DEPTH_LOG2-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]     rdata_o
);

  localparam int unsigned NBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth  = 1 << MEM_DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Stored line with this cycle's write bytes overlaid, for write-first reads.
  always_comb begin
    merged = mem[raddr_i];
    for (int b = 0; b < NBytes; b++) begin
      if (wbe_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NBytes; b++) begin
        if (wbe_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? merged : mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_mem_burst_responder.sv
// Avalon-MM slave terminating an avalon_mem_if with a small byte-enabled RAM.
//   clk, reset_n                      : clock, async active-low reset
//   address, burstcount               : command, sampled on the first beat only
//   read, write, writedata, byteenable: requests and write beat data
//   waitrequest                       : beat not accepted while high
//   readdata, readdatavalid           : read beats, two cycles after command accept
//   stall_req                         : forces waitrequest for backpressure tests
//   err_pulse                         : one-cycle flag after a protocol violation
//   busy                              : burst in progress or read beat outstanding
module avalon_mem_burst_responder
  import avalon_mem_burst_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 27,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 7,
  parameter int unsigned MEM_DEPTH_LOG2  = 10
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [ADDR_WIDTH-1:0]                address,
  input  logic [BURST_CNT_WIDTH-1:0]           burstcount,
  input  logic                                 read,
  input  logic                                 write,
  input  logic [DATA_WIDTH-1:0]                writedata,
  input  logic [byte_count(DATA_WIDTH)-1:0]    byteenable,
  output logic                                 waitrequest,
  output logic [DATA_WIDTH-1:0]                readdata,
  output logic                                 readdatavalid,
  input  logic                                 stall_req,
  output logic                                 err_pulse,
  output logic                                 busy
);

  localparam int unsigned AW = MEM_DEPTH_LOG2;
  localparam int unsigned BW = BURST_CNT_WIDTH;

  t_rsp_state      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   rem_q, rem_d;
  logic            err_q, err_d;
  logic            rdv_q;
  logic [1:0]      rst_sync_q;
  logic            accept;
  logic [BW-1:0]   bc_eff;
  logic [AW-1:0]   cmd_addr;
  logic            ram_we, ram_re;
  logic [AW-1:0]   ram_waddr;
  logic            unused_addr;

  // Deassertion synchronizer: holds waitrequest for two edges after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign waitrequest = !rst_sync_q[1] | stall_req | (state_q == StRdBurst);
  assign accept      = (read | write) & ~waitrequest;
  assign bc_eff      = (burstcount == '0) ? BW'(1) : burstcount;
  assign cmd_addr    = address[AW-1:0];
  // Only the low address bits index the store; the rest wrap modulo the depth.
  assign unused_addr = ^address;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    err_d     = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = addr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (write) begin
            // read+write together is served as a write and flagged.
            ram_we    = 1'b1;
            ram_waddr = cmd_addr;
            addr_d    = cmd_addr + AW'(1);
            rem_d     = bc_eff - BW'(1);
            err_d     = read | (burstcount == '0);
            if (bc_eff != BW'(1)) state_d = StWrBurst;
          end else begin
            addr_d  = cmd_addr;
            rem_d   = bc_eff;
            err_d   = (burstcount == '0);
            state_d = StRdBurst;
          end
        end
      end
      StWrBurst: begin
        if (accept) begin
          err_d = read;
          if (write) begin
            ram_we = 1'b1;
            addr_d = addr_q + AW'(1);
            rem_d  = rem_q - BW'(1);
            if (rem_q == BW'(1)) state_d = StIdle;
          end
        end
      end
      StRdBurst: begin
        // Issues one beat per cycle; stall_req only gates command acceptance.
        ram_re = 1'b1;
        addr_d = addr_q + AW'(1);
        rem_d  = rem_q - BW'(1);
        if (rem_q == BW'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      rdv_q   <= ram_re;
    end
  end

  avalon_mem_responder_ram #(
    .DATA_WIDTH     (DATA_WIDTH),
    .MEM_DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (writedata),
    .wbe_i   (byteenable),
    .re_i    (ram_re),
    .raddr_i (addr_q),
    .rdata_o (readdata)
  );

  assign readdatavalid = rdv_q;
  assign err_pulse     = err_q;
  assign busy          = (state_q != StIdle) | rdv_q;

endmodule

// File: tb/tb_avalon_mem_burst_responder.sv
module tb_avalon_mem_burst_responder;

  localparam int AW = 27;
  localparam int DW = 512;
  localparam int BW = 7;
  localparam int NB = DW / 8;
  localparam int Depth = 1024;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic [BW-1:0] burstcount = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] writedata = '0;
  logic [NB-1:0] byteenable = '0;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          stall_req = 1'b0;
  logic          err_pulse;
  logic          busy;

  always #5 clk = ~clk;

  avalon_mem_burst_responder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .burstcount    (burstcount),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .stall_req     (stall_req),
    .err_pulse     (err_pulse),
    .busy          (busy)
  );

  // Reference memory: updated from the stimulus as write beats are accepted.
  logic [DW-1:0] model [Depth];

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int err_seen = 0;
  int stray_rdv = 0;
  bit sb_off = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each valid beat must match the oldest expectation, in data and cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (err_pulse) err_seen++;
      if (readdatavalid) begin
        if (sb_off) begin
          stray_rdv++;
        end else begin
          tests++;
          if (sbq.size() == 0) begin
            fails++;
            $display("FAIL rdv_unexpected: readdatavalid=1 at cycle %0d, required 0", cyc);
          end else begin
            mon_e = sbq.pop_front();
            if (readdata !== mon_e.data || cyc != mon_e.cyc) begin
              fails++;
              $display("FAIL rd_beat: got data=%0h cycle=%0d, required data=%0h cycle=%0d",
                       readdata, cyc, mon_e.data, mon_e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input int bc, input logic [DW-1:0] base,
                          input logic [NB-1:0] be, input int rd_beat, input bit stall_tog);
    int n;
    int k;
    int budget;
    bit acc;
    logic [DW-1:0] d;
    n = (bc == 0) ? 1 : bc;
    k = 0;
    budget = 0;
    while (k < n && budget < 200) begin
      d          = base + DW'(k);
      write      = 1'b1;
      writedata  = d;
      byteenable = be;
      read       = (k == rd_beat);
      // Later beats carry junk command fields, which must be ignored.
      address    = (k == 0) ? AW'(a) : AW'(27'h5A5);
      burstcount = (k == 0) ? BW'(bc) : BW'(9);
      @(negedge clk);
      acc = !waitrequest;
      step();
      if (acc) begin
        for (int b = 0; b < NB; b++)
          if (be[b]) model[(a + k) % Depth][8*b +: 8] = d[8*b +: 8];
        k++;
      end
      if (stall_tog) stall_req = ~stall_req;
      budget++;
    end
    write = 1'b0;
    read = 1'b0;
    stall_req = 1'b0;
    if (k < n) begin
      tests++;
      fails++;
      $display("FAIL wr_timeout: got %0d beats accepted, required %0d", k, n);
    end
  endtask

  task automatic do_read(input int a, input int bc);
    int n;
    int budget;
    bit acc;
    n = (bc == 0) ? 1 : bc;
    budget = 0;
    acc = 1'b0;
    read = 1'b1;
    address = AW'(a);
    burstcount = BW'(bc);
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = !waitrequest;
      if (acc && !sb_off)
        for (int k = 0; k < n; k++) sbq.push_back('{model[(a + k) % Depth], cyc + 2 + k});
      step();
      budget++;
    end
    read = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL rd_timeout: got no acceptance, required acceptance");
    end
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (sbq.size() > 0 && budget < 100) begin
      step();
      budget++;
    end
    chk_int("drain", sbq.size(), 0);
  endtask

  typedef struct {
    bit            is_rd;
    int            addr;
    int            bc;
    logic [DW-1:0] base;
    logic [NB-1:0] be;
    int            rd_beat;
    bit            stall_tog;
    int            exp_err;
  } op_t;
  op_t ops[$];

  initial begin
    int e0;
    logic [NB-1:0] be_full;
    logic [NB-1:0] be_lo4;
    logic [DW-1:0] ones;
    logic [DW-1:0] a5;
    be_full = '1;
    be_lo4  = NB'(64'hF);
    ones    = '1;
    a5      = {NB{8'hA5}};

    //            rd    addr  bc  base        be       rdb st err
    ops.push_back('{1'b0, 5,    1, a5,         be_full, -1, 0, 0});
    ops.push_back('{1'b1, 5,    1, '0,         '0,      -1, 0, 0});
    ops.push_back('{1'b0, 10,   4, DW'(0),     be_full, -1, 0, 0});
    ops.push_back('{1'b1, 10,   4, '0,         '0,      -1, 0, 0});
    ops.push_back('{1'b0, 20,   1, ones,       be_full, -1, 0, 0});
    ops.push_back('{1'b0, 20,   1, DW'(0),     be_lo4,  -1, 0, 0});
    ops.push_back('{1'b1, 20,   1, '0,         '0,      -1, 0, 0});
    ops.push_back('{1'b0, 1022, 3, DW'('h100), be_full, -1, 0, 0});
    ops.push_back('{1'b1, 0,    1, '0,         '0,      -1, 0, 0});
    ops.push_back('{1'b1, 1022, 3, '0,         '0,      -1, 0, 0});
    ops.push_back('{1'b0, 30,   2, DW'('h200), be_full, 0,  0, 1});
    ops.push_back('{1'b1, 30,   2, '0,         '0,      -1, 0, 0});
    ops.push_back('{1'b0, 40,   0, DW'('h300), be_full, -1, 0, 1});
    ops.push_back('{1'b1, 40,   1, '0,         '0,      -1, 0, 0});
    ops.push_back('{1'b0, 50,   3, DW'('h400), be_full, 1,  0, 1});
    ops.push_back('{1'b1, 50,   3, '0,         '0,      -1, 0, 0});
    ops.push_back('{1'b1, 40,   0, '0,         '0,      -1, 0, 1});
    ops.push_back('{1'b0, 60,   4, DW'('h500), be_full, -1, 1, 0});
    ops.push_back('{1'b1, 60,   4, '0,         '0,      -1, 0, 0});
    ops.push_back('{1'b0, 70,   1, ones,       be_full, -1, 0, 0});
    ops.push_back('{1'b0, 70,   1, DW'(0),     '0,      -1, 0, 0});
    ops.push_back('{1'b1, 70,   1, '0,         '0,      -1, 0, 0});

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_waitrequest", DW'(waitrequest), DW'(1));
    chk("rst_rdv", DW'(readdatavalid), DW'(0));
    chk("rst_readdata", readdata, '0);
    chk("rst_err", DW'(err_pulse), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_wait_c0", DW'(waitrequest), DW'(1));
    step();
    @(negedge clk);
    chk("rel_wait_c1", DW'(waitrequest), DW'(1));
    step();
    @(negedge clk);
    chk("rel_wait_c2", DW'(waitrequest), DW'(0));
    step();

    for (int i = 0; i < ops.size(); i++) begin
      e0 = err_seen;
      if (ops[i].is_rd) do_read(ops[i].addr, ops[i].bc);
      else do_write(ops[i].addr, ops[i].bc, ops[i].base, ops[i].be, ops[i].rd_beat,
                    ops[i].stall_tog);
      step();
      chk_int($sformatf("err_count_op%0d", i), err_seen - e0, ops[i].exp_err);
    end
    wait_drain();
    // Spot checks of the model against hand-derived values.
    chk("model_partial", model[20], {{(NB-4){8'hFF}}, 32'h0});
    chk("model_wrap0", model[0], DW'('h102));

    // Read accepted the cycle right after a write's final beat.
    do_write(80, 1, DW'('hDEAD), be_full, -1, 1'b0);
    do_read(80, 1);
    wait_drain();

    // waitrequest/busy window of a 4-beat read, then readdata holds.
    do_read(10, 4);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("rd_wait_c%0d", j), DW'(waitrequest), DW'(1));
      chk($sformatf("rd_busy_c%0d", j), DW'(busy), DW'(1));
      step();
    end
    @(negedge clk);
    chk("rd_wait_done", DW'(waitrequest), DW'(0));
    wait_drain();
    step();
    @(negedge clk);
    chk("readdata_hold", readdata, DW'(3));
    chk("rdv_idle", DW'(readdatavalid), DW'(0));
    step();

    // Asynchronous reset in the middle of an 8-beat read.
    sb_off = 1'b1;
    do_read(10, 8);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdv", DW'(readdatavalid), DW'(0));
    chk("mid_rst_wait", DW'(waitrequest), DW'(1));
    chk("mid_rst_busy", DW'(busy), DW'(0));
    step();
    step();
    reset_n = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk($sformatf("post_rst_wait_c%0d", j), DW'(waitrequest), DW'(1));
      chk($sformatf("post_rst_rdv_c%0d", j), DW'(readdatavalid), DW'(0));
      step();
    end
    @(negedge clk);
    chk("post_rst_wait_low", DW'(waitrequest), DW'(0));
    chk("post_rst_rdv_low", DW'(readdatavalid), DW'(0));
    step();
    sb_off = 1'b0;
    do_read(10, 4);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
